alu_issue_stage: RTL and testbench

//  Issue/capture stage in front of the 16-bit combinational ALU. Accepts one

---
 rtl/alu_issue_stage.sv | 138 +++++++++++++
 tb/tb_alu_issue_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue/capture stage in front of the 16-bit combinational ALU: latches one op per
// handshake, presents it to the ALU after a one-cycle idle gap, then captures the result.
module alu_issue_stage #(
  parameter int SETTLE_CYCLES = 1,
  parameter int DEST_W        = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [15:0]       in_a,
  input  logic [15:0]       in_b,
  input  logic [2:0]        in_ltgt,
  input  logic              in_eq,
  input  logic [DEST_W-1:0] in_dest,
  output logic [3:0]        alu_op,
  output logic [15:0]       alu_res,
  output logic [15:0]       alu_register,
  output logic [2:0]        alu_ltgt,
  output logic              alu_eq,
  input  logic [15:0]       alu_out,
  input  logic              alu_compres,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_is_branch,
  output logic              out_taken,
  output logic              out_illegal
);

  localparam logic [3:0] IDLE_OP = 4'h7;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, GAP, EXEC, DONE} state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   count;
  logic [3:0]         lat_op;
  logic [DEST_W-1:0]  lat_dest;
  logic               op_legal;
  logic               op_branch;
  logic               accept;
  logic               last_exec;

  // Branches are only meaningful with a known compare select.
  always_comb begin
    op_legal  = 1'b0;
    op_branch = (lat_op == 4'd4);
    case (lat_op)
      4'd0, 4'd2, 4'd3, 4'd5: op_legal = 1'b1;
      4'd4:                   op_legal = (alu_ltgt <= 3'd2);
      default:                op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Illegal ops keep the ALU parked on IDLE_OP so nothing stale is ever sampled.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    alu_op     = IDLE_OP;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = GAP;
      end
      GAP: next_state = EXEC;
      EXEC: begin
        if (op_legal) alu_op = lat_op;
        if (count == '0) next_state = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) next_state = in_valid ? GAP : IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (flush) begin
      next_state = IDLE;
      in_ready   = 1'b0;
      alu_op     = IDLE_OP;
    end
    accept    = in_valid && in_ready;
    last_exec = (state == EXEC) && (count == '0) && !flush;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_op        <= 4'd0;
      lat_dest      <= '0;
      alu_res       <= 16'd0;
      alu_register  <= 16'd0;
      alu_ltgt      <= 3'd0;
      alu_eq        <= 1'b0;
      count         <= '0;
      out_valid     <= 1'b0;
      out_result    <= 16'd0;
      out_dest      <= '0;
      out_is_branch <= 1'b0;
      out_taken     <= 1'b0;
      out_illegal   <= 1'b0;
    end else begin
      if (accept) begin
        lat_op       <= in_op;
        lat_dest     <= in_dest;
        alu_res      <= in_a;
        alu_register <= in_b;
        alu_ltgt     <= in_ltgt;
        alu_eq       <= in_eq;
      end
      if (state == GAP)
        count <= CNT_W'(SETTLE_CYCLES - 1);
      else if (state == EXEC && count != '0)
        count <= count - 1'b1;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (last_exec) begin
        out_valid     <= 1'b1;
        out_dest      <= lat_dest;
        out_is_branch <= op_branch;
        out_illegal   <= !op_legal;
        out_result    <= (op_legal && !op_branch) ? alu_out : 16'd0;
        out_taken     <= op_legal && op_branch && alu_compres;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a behavioural ALU model feeds alu_out/compres,
// a vector table covers every op class, and hand sequences cover the timing corners.
module tb_alu_issue_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_op = 4'd0;
  logic [15:0] in_a = 16'd0;
  logic [15:0] in_b = 16'd0;
  logic [2:0]  in_ltgt = 3'd0;
  logic        in_eq = 1'b0;
  logic [3:0]  in_dest = 4'd0;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [15:0] alu_res, alu_register, alu_out;
  logic [2:0]  alu_ltgt;
  logic        alu_eq, alu_compres;
  logic        out_valid, out_is_branch, out_taken, out_illegal;
  logic [15:0] out_result;
  logic [3:0]  out_dest;

  logic        s3_in_valid = 1'b0;
  logic        s3_out_ready = 1'b0;
  logic        s3_flush = 1'b0;
  logic [3:0]  s3_in_op = 4'd0;
  logic [15:0] s3_in_a = 16'd0;
  logic [15:0] s3_in_b = 16'd0;
  logic        s3_in_eq = 1'b0;
  logic [3:0]  s3_in_dest = 4'd0;
  logic        s3_in_ready;
  logic [3:0]  s3_alu_op;
  logic [15:0] s3_alu_res, s3_alu_register, s3_alu_out;
  logic [2:0]  s3_alu_ltgt;
  logic        s3_alu_eq, s3_alu_compres;
  logic        s3_out_valid, s3_out_is_branch, s3_out_taken, s3_out_illegal;
  logic [15:0] s3_out_result;
  logic [3:0]  s3_out_dest;

  int pass_count = 0;
  int check_count = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  ltgt;
    logic        eq;
    logic [3:0]  dest;
    logic [15:0] result;
    logic        branch;
    logic        taken;
    logic        illegal;
  } vec_t;

  vec_t vecs[12];
  int   exp_b2b_op[6] = '{7, 5, 7, 7, 5, 7};
  int   exp_b2b_ov[6] = '{0, 0, 1, 0, 0, 1};

  alu_issue_stage #(.SETTLE_CYCLES(1), .DEST_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .in_ltgt(in_ltgt), .in_eq(in_eq), .in_dest(in_dest),
    .alu_op(alu_op), .alu_res(alu_res), .alu_register(alu_register),
    .alu_ltgt(alu_ltgt), .alu_eq(alu_eq), .alu_out(alu_out), .alu_compres(alu_compres),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest(out_dest), .out_is_branch(out_is_branch), .out_taken(out_taken),
    .out_illegal(out_illegal)
  );

  alu_issue_stage #(.SETTLE_CYCLES(3), .DEST_W(4)) dut3 (
    .clock(clock), .reset_n(reset_n), .flush(s3_flush),
    .in_valid(s3_in_valid), .in_ready(s3_in_ready), .in_op(s3_in_op), .in_a(s3_in_a),
    .in_b(s3_in_b), .in_ltgt(3'd0), .in_eq(s3_in_eq), .in_dest(s3_in_dest),
    .alu_op(s3_alu_op), .alu_res(s3_alu_res), .alu_register(s3_alu_register),
    .alu_ltgt(s3_alu_ltgt), .alu_eq(s3_alu_eq), .alu_out(s3_alu_out),
    .alu_compres(s3_alu_compres),
    .out_valid(s3_out_valid), .out_ready(s3_out_ready), .out_result(s3_out_result),
    .out_dest(s3_out_dest), .out_is_branch(s3_out_is_branch), .out_taken(s3_out_taken),
    .out_illegal(s3_out_illegal)
  );

  // Non-computing codes return junk so any capture of a parked ALU shows up.
  function automatic logic [16:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [2:0] ltgt,
                                            input logic eq);
    logic cond;
    cond = 1'b0;
    case (ltgt)
      3'd0:    cond = (a == b);
      3'd1:    cond = (a <= b);
      3'd2:    cond = (a >= b);
      default: cond = 1'b0;
    endcase
    case (op)
      4'd0:    return {1'b1, eq ? 16'(a + b) : 16'(a - b)};
      4'd2:    return {1'b1, a & b};
      4'd3:    return {1'b1, a | b};
      4'd4:    return {eq ? cond : !cond, 16'h5A5A};
      4'd5:    return {1'b1, 15'd0, ^a};
      default: return {1'b1, 16'hDEAD};
    endcase
  endfunction

  assign {alu_compres, alu_out} = alu_model(alu_op, alu_res, alu_register, alu_ltgt, alu_eq);
  assign {s3_alu_compres, s3_alu_out} =
    alu_model(s3_alu_op, s3_alu_res, s3_alu_register, s3_alu_ltgt, s3_alu_eq);

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input vec_t v);
    int lat;
    int waited;
    logic [3:0] exec_op;
    in_op = v.op; in_a = v.a; in_b = v.b; in_ltgt = v.ltgt; in_eq = v.eq; in_dest = v.dest;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clock); #1; waited++;
    end
    checkOutput("in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    checkOutput("gap_alu_op", 32'(alu_op), 32'd7);
    checkOutput("gap_alu_res", 32'(alu_res), 32'(v.a));
    checkOutput("gap_alu_register", 32'(alu_register), 32'(v.b));
    lat = 0;
    exec_op = 4'hF;
    while (!out_valid && lat < 10) begin
      @(posedge clock); #1; lat++;
      if (lat == 1) exec_op = alu_op;
    end
    checkOutput("latency", 32'(lat), 32'd2);
    checkOutput("exec_alu_op", 32'(exec_op), v.illegal ? 32'd7 : 32'(v.op));
    checkOutput("out_result", 32'(out_result), 32'(v.result));
    checkOutput("out_dest", 32'(out_dest), 32'(v.dest));
    checkOutput("out_is_branch", 32'(out_is_branch), 32'(v.branch));
    checkOutput("out_taken", 32'(out_taken), 32'(v.taken));
    checkOutput("out_illegal", 32'(out_illegal), 32'(v.illegal));
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checkOutput("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int exec_cycles;
    //          op     a         b         ltgt  eq    dest   result    br    tk    ill
    vecs[0]  = '{4'd0, 16'd100,  16'd23,   3'd0, 1'b1, 4'd3,  16'd123,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'd0, 16'd100,  16'd23,   3'd0, 1'b0, 4'd9,  16'd77,   1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'd2, 16'hF0F0, 16'hFF00, 3'd0, 1'b0, 4'd1,  16'hF000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'd3, 16'h00F0, 16'h0F00, 3'd0, 1'b0, 4'd2,  16'h0FF0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'd5, 16'h0007, 16'd0,    3'd0, 1'b0, 4'd4,  16'd1,    1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'd4, 16'd5,    16'd5,    3'd1, 1'b1, 4'd5,  16'd0,    1'b1, 1'b1, 1'b0};
    vecs[6]  = '{4'd4, 16'd5,    16'd6,    3'd0, 1'b1, 4'd6,  16'd0,    1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'd4, 16'd9,    16'd5,    3'd2, 1'b1, 4'd7,  16'd0,    1'b1, 1'b1, 1'b0};
    vecs[8]  = '{4'd4, 16'd5,    16'd6,    3'd0, 1'b0, 4'd8,  16'd0,    1'b1, 1'b1, 1'b0};
    vecs[9]  = '{4'd4, 16'd5,    16'd5,    3'd3, 1'b1, 4'd10, 16'd0,    1'b1, 1'b0, 1'b1};
    vecs[10] = '{4'd1, 16'd100,  16'd23,   3'd0, 1'b1, 4'd11, 16'd0,    1'b0, 1'b0, 1'b1};
    vecs[11] = '{4'd8, 16'd100,  16'd23,   3'd0, 1'b1, 4'd12, 16'd0,    1'b0, 1'b0, 1'b1};

    #12;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_alu_op", 32'(alu_op), 32'd7);
    checkOutput("reset_alu_res", 32'(alu_res), 32'd0);
    checkOutput("reset_out_result", 32'(out_result), 32'd0);
    checkOutput("reset_s3_alu_op", 32'(s3_alu_op), 32'd7);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Backpressure: result must hold while a new op waits upstream.
    in_op = 4'd0; in_a = 16'd1; in_b = 16'd2; in_eq = 1'b1; in_ltgt = 3'd0; in_dest = 4'd5;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    in_op = 4'd3; in_a = 16'h00F0; in_b = 16'h000F; in_dest = 4'd6; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_hold_result", 32'(out_result), 32'd3);
      checkOutput("bp_hold_dest", 32'(out_dest), 32'd5);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    checkOutput("bp_next_gap_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_next_gap_op", 32'(alu_op), 32'd7);
    checkOutput("bp_next_gap_res", 32'(alu_res), 32'h00F0);
    @(posedge clock); #1;
    checkOutput("bp_next_exec_op", 32'(alu_op), 32'd3);
    @(posedge clock); #1;
    checkOutput("bp_next_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_next_result", 32'(out_result), 32'h00FF);
    checkOutput("bp_next_dest", 32'(out_dest), 32'd6);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;

    // Back-to-back identical ops must still pass through IDLE_OP between executions.
    in_op = 4'd5; in_a = 16'h0007; in_b = 16'd0; in_dest = 4'd1;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      checkOutput("b2b_alu_op", 32'(alu_op), 32'(exp_b2b_op[k]));
      checkOutput("b2b_out_valid", 32'(out_valid), 32'(exp_b2b_ov[k]));
      if (exp_b2b_ov[k] == 1) checkOutput("b2b_out_result", 32'(out_result), 32'd1);
      if (k == 3) in_valid = 1'b0;
    end
    @(posedge clock); #1;
    out_ready = 1'b0;

    // Flush in IDLE swallows the offered op; flush in GAP kills the accepted one.
    flush = 1'b1; in_valid = 1'b1; in_op = 4'd0; in_a = 16'hBEEF;
    #1;
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_no_accept_res", 32'(alu_res), 32'h0007);
    checkOutput("flush_idle_op", 32'(alu_op), 32'd7);
    in_op = 4'd0; in_a = 16'd10; in_b = 16'd4; in_eq = 1'b0; in_dest = 4'd2; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b1;
    #1;
    checkOutput("flush_gap_in_ready", 32'(in_ready), 32'd0);
    checkOutput("flush_gap_alu_op", 32'(alu_op), 32'd7);
    @(posedge clock); #1;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("flush_no_valid", 32'(out_valid), 32'd0);
      checkOutput("flush_stays_idle", 32'(alu_op), 32'd7);
      @(posedge clock); #1;
    end
    applyStimulus(vecs[0]);

    // Asynchronous reset in the middle of EXEC.
    in_op = 4'd2; in_a = 16'hFFFF; in_b = 16'h00FF; in_dest = 4'd4; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    checkOutput("pre_reset_exec_op", 32'(alu_op), 32'd2);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_reset_alu_op", 32'(alu_op), 32'd7);
    checkOutput("mid_reset_alu_res", 32'(alu_res), 32'd0);
    checkOutput("mid_reset_out_result", 32'(out_result), 32'd0);
    checkOutput("mid_reset_out_dest", 32'(out_dest), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    checkOutput("after_reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("after_reset_out_valid", 32'(out_valid), 32'd0);

    // Three-cycle settle window: latency four edges, three EXEC cycles on the ALU.
    s3_in_op = 4'd0; s3_in_a = 16'd2; s3_in_b = 16'd3; s3_in_eq = 1'b1; s3_in_dest = 4'd7;
    s3_in_valid = 1'b1;
    @(posedge clock); #1;
    s3_in_valid = 1'b0;
    checkOutput("s3_gap_op", 32'(s3_alu_op), 32'd7);
    lat = 0;
    exec_cycles = 0;
    while (!s3_out_valid && lat < 20) begin
      @(posedge clock); #1; lat++;
      if (!s3_out_valid && s3_alu_op == 4'd0) exec_cycles++;
    end
    checkOutput("s3_latency", 32'(lat), 32'd4);
    checkOutput("s3_exec_cycles", 32'(exec_cycles), 32'd3);
    checkOutput("s3_out_result", 32'(s3_out_result), 32'd5);
    checkOutput("s3_out_dest", 32'(s3_out_dest), 32'd7);
    s3_out_ready = 1'b1;
    @(posedge clock); #1;
    s3_out_ready = 1'b0;
    checkOutput("s3_out_valid_drop", 32'(s3_out_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
